// File: rtl/dac_axis_waveform_player_if.sv
// Buffer-load, playback-control, AXI4-Stream and status signals of the DAC waveform player.
// master = player side, slave = host/RF-DAC side.
interface dac_axis_waveform_player_if #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int ADDR_WIDTH     = 10
);
    localparam int DATA_WIDTH = 16 * NUMBER_OF_LINE;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  start;
    logic                  stop;
    logic [ADDR_WIDTH-1:0] play_length;
    logic                  loop_enable;
    logic                  m_axis_tvalid;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tready;
    logic                  busy;
    logic                  done;
    logic [31:0]           beat_count;

    modport master (
        input  wr_en, wr_addr, wr_data, start, stop, play_length, loop_enable, m_axis_tready,
        output m_axis_tvalid, m_axis_tdata, busy, done, beat_count
    );

    modport slave (
        output wr_en, wr_addr, wr_data, start, stop, play_length, loop_enable, m_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, busy, done, beat_count
    );
endinterface

// File: rtl/dac_axis_waveform_player.sv
// Plays a stored waveform from a dual-port buffer onto an AXI4-Stream master, one-shot or looped.
// Start-to-first-tvalid is 2 cycles; tready backpressure is absorbed by a 2-entry skid stage.
module dac_axis_waveform_player #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int ADDR_WIDTH     = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    dac_axis_waveform_player_if.master  bus
);
    localparam int DW    = 16 * NUMBER_OF_LINE;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] rd_addr_q, last_addr_q;
    logic                  loop_mode_q;
    logic                  rd_vld_q;
    logic [DW-1:0]         rd_dat_q;
    logic                  out_vld_q, skid_vld_q;
    logic [DW-1:0]         out_dat_q, skid_dat_q;
    logic [31:0]           beat_count_q;

    logic       pop, start_ok, at_last, pipe_empty, head_free;
    logic       rd_issue, busy_c, done_c;
    logic [1:0] pending;

    assign pop        = out_vld_q & bus.m_axis_tready;
    assign head_free  = ~out_vld_q | pop;
    assign start_ok   = bus.start & ~bus.stop;
    assign at_last    = (rd_addr_q == last_addr_q);
    assign pipe_empty = ~rd_vld_q & ~out_vld_q & ~skid_vld_q;
    // Occupancy net of the beat leaving this cycle, so a full-rate stream never stalls the reads.
    assign pending    = 2'(rd_vld_q) + 2'(out_vld_q) + 2'(skid_vld_q) - 2'(pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_PLAY;
            S_PLAY:  if (bus.stop || (rd_issue && at_last && !loop_mode_q)) state_d = S_DRAIN;
            S_DRAIN: if (pipe_empty) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c   = (state_q != S_IDLE);
        done_c   = (state_q == S_DRAIN) && pipe_empty;
        rd_issue = (state_q == S_PLAY) && (pending < 2'd2);
    end

    // Buffer: no reset on contents; nonblocking read gives read-first on address collision.
    always_ff @(posedge clock) begin
        if (bus.wr_en)
            mem[bus.wr_addr] <= bus.wr_data;
        if (rd_issue)
            rd_dat_q <= mem[rd_addr_q];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_addr_q    <= '0;
            last_addr_q  <= '0;
            loop_mode_q  <= 1'b0;
            rd_vld_q     <= 1'b0;
            out_vld_q    <= 1'b0;
            out_dat_q    <= '0;
            skid_vld_q   <= 1'b0;
            skid_dat_q   <= '0;
            beat_count_q <= '0;
        end else begin
            rd_vld_q <= rd_issue;

            if (state_q == S_IDLE && start_ok) begin
                last_addr_q <= bus.play_length;
                loop_mode_q <= bus.loop_enable;
                rd_addr_q   <= '0;
            end else if (rd_issue) begin
                rd_addr_q <= at_last ? '0 : rd_addr_q + 1'b1;
            end

            if (state_q == S_IDLE && start_ok)
                beat_count_q <= '0;
            else if (pop)
                beat_count_q <= beat_count_q + 32'd1;

            // Head is the presented beat; the skid entry only fills while the head is stalled.
            if (head_free) begin
                if (skid_vld_q) begin
                    out_vld_q  <= 1'b1;
                    out_dat_q  <= skid_dat_q;
                    skid_vld_q <= rd_vld_q;
                    if (rd_vld_q) skid_dat_q <= rd_dat_q;
                end else begin
                    out_vld_q <= rd_vld_q;
                    if (rd_vld_q) out_dat_q <= rd_dat_q;
                end
            end else if (rd_vld_q) begin
                skid_vld_q <= 1'b1;
                skid_dat_q <= rd_dat_q;
            end

            if (done_c)
                out_dat_q <= '0;
        end
    end

    assign bus.m_axis_tvalid = out_vld_q;
    assign bus.m_axis_tdata  = out_dat_q;
    assign bus.busy          = busy_c;
    assign bus.done          = done_c;
    assign bus.beat_count    = beat_count_q;
endmodule

// File: doc/dac_axis_waveform_player.md
Name: dac_axis_waveform_player

Overview:
AXI4-Stream master that plays a stored multi-sample waveform into one RF-DAC tile stream, the transmit counterpart to the ADC capture path. Software or upstream logic loads a dual-port sample buffer through a simple write port. Start triggers one-shot or looped playback. The block honours m_axis_tready backpressure without dropping or duplicating beats, unlike a free-running tvalid=1 DAC feed.

Parameters:
NUMBER_OF_LINE, 8, samples per AXIS beat (16 bits each); beat width is 16*NUMBER_OF_LINE
ADDR_WIDTH, 10, buffer depth is 2**ADDR_WIDTH beats

Ports:
clock  input  1  single clock for all logic (500 MHz DAC fabric clock)
reset  input  1  asynchronous, active-high reset
wr_en  input  1  buffer write strobe
wr_addr  input  ADDR_WIDTH  buffer write address
wr_data  input  16*NUMBER_OF_LINE  buffer write data
start  input  1  single-cycle playback request
stop  input  1  single-cycle abort request
play_length  input  ADDR_WIDTH  index of last beat to play (beats played = play_length+1)
loop_enable  input  1  1 = wrap to address 0 after last beat
m_axis_tvalid  output  1  AXIS valid
m_axis_tdata  output  16*NUMBER_OF_LINE  AXIS data
m_axis_tready  input  1  AXIS ready from RF-DAC
busy  output  1  high in PLAY or DRAIN
done  output  1  one-cycle pulse when playback fully completes
beat_count  output  32  beats accepted (tvalid&tready) since last start; wraps modulo 2**32

Behaviour:
- Reset (async assert, sync release on clock edge): state IDLE, m_axis_tvalid=0, m_axis_tdata=0, busy=0, done=0, beat_count=0, read address 0. Buffer contents are not reset.
- Buffer: 2**ADDR_WIDTH x 16*NUMBER_OF_LINE simple dual-port RAM, 1-cycle synchronous read. Writes are accepted in every state. A same-address read/write in one cycle returns the old data (read-first).
- Output stage: 2-entry skid buffer after the RAM read register.
  - A read is issued only when the in-flight reads plus occupied skid entries total fewer than 2.
  - tready held high gives one beat per cycle with no bubbles.
- AXIS rules:
  - Once tvalid=1, tvalid and tdata hold until tready=1.
  - A beat transfers on tvalid&tready at the rising edge.
  - tvalid never depends combinationally on tready.
- States:
  - IDLE: busy=0. On start=1 and stop=0: latch play_length as last_addr and loop_enable as loop_mode, clear beat_count, read address = 0, go to PLAY. If start and stop are both 1, stop wins and the block stays in IDLE. stop alone in IDLE has no effect.
  - PLAY: issue reads at ascending addresses.
    - After issuing last_addr: if loop_mode, next address is 0 and the block stays in PLAY; otherwise go to DRAIN.
    - stop=1 halts further reads and goes to DRAIN; a read issued in that same cycle still completes.
    - start is ignored while busy.
  - DRAIN: no new reads. Deliver all in-flight and buffered beats (at most 2). When the pipeline is empty and the last beat is accepted, pulse done=1 for one cycle, then go to IDLE. tvalid=0 in the cycle done pulses.
- Latency: with tready=1, start sampled at edge N gives tvalid=1 with beat 0 after edge N+2.
- play_length=0 plays exactly one beat; with loop_mode it repeats beat 0 every cycle.
- In loop mode, wrap from last_addr to 0 is seamless: no bubble when tready=1.
- m_axis_tdata reads 0 while tvalid=0 in IDLE. Otherwise it holds the last presented beat until the next beat loads.
- Reset asserted mid-playback: all outputs go immediately to their reset values and pending beats are discarded.

Test Plan:
- Write beats 0x1111..,0x2222..,0x3333..,0x4444.. (each 16-bit lane equal) at addresses 0-3; set play_length=3, loop_enable=0, tready=1; pulse start -> tvalid rises after edge N+2 and presents exactly 4 consecutive beats in order; done pulses once after the 4th beat; beat_count=4; busy falls with done.
- Same load; tready pattern 1,0,0,1,0,1,1,... -> tdata stable whenever tvalid&!tready; receiver collects exactly 0x1111,0x2222,0x3333,0x4444 with no drop or duplicate; beat_count=4.
- play_length=1, loop_enable=1, tready=1, start, then stop after 5 accepted beats -> beats alternate A,B,A,B,A with at most 2 further beats continuing the pattern; done pulses; beat_count is 5-7 and equals the beats received.
- start and stop asserted in the same cycle in IDLE -> tvalid stays 0, busy=0, no done. start pulsed during PLAY -> ignored, sequence unchanged.
- play_length=0, loop_enable=0 -> exactly one beat, done pulse, beat_count=1. Then write address 0 with a new value and restart -> the new value is played.
- Assert reset while tvalid=1 and tready=0 mid-playback -> tvalid=0, tdata=0, busy=0, beat_count=0 immediately. After release, a new start plays from address 0.
